// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the set-associative write-back cache.
package cache_pkg;

    localparam int BEATS_PER_LINE = 4;
    localparam int MEM_DATA_BITS  = 128;
    localparam int OFFSET_BITS    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB_REQ,
        ST_WB_DATA,
        ST_FILL_REQ,
        ST_FILL_DATA,
        ST_REPLAY
    } state_t;

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int addr_bits, input int lines);
        return addr_bits - $clog2(lines) - OFFSET_BITS;
    endfunction

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_meta_array.sv
// Per-way valid/dirty/tag storage; valid and dirty clear asynchronously on reset.
module cache_meta_array
    import cache_pkg::*;
#(
    parameter int LINES    = 64,
    parameter int WAYS     = 2,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 20,
    parameter int WAY_BITS = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [IDX_BITS-1:0]        i_idx,
    input  logic [WAY_BITS-1:0]        i_way,
    input  logic                       i_fill_we,
    input  logic [TAG_BITS-1:0]        i_fill_tag,
    input  logic                       i_set_dirty,
    output logic [WAYS-1:0]            o_valid,
    output logic [WAYS-1:0]            o_dirty,
    output logic [WAYS*TAG_BITS-1:0]   o_tags
);

    logic [LINES-1:0]    r_valid [WAYS];
    logic [LINES-1:0]    r_dirty [WAYS];
    logic [TAG_BITS-1:0] r_tag   [WAYS][LINES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
        end else if (i_fill_we) begin
            r_valid[i_way][i_idx] <= 1'b1;
            r_dirty[i_way][i_idx] <= 1'b0;
        end else if (i_set_dirty) begin
            r_dirty[i_way][i_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_fill_we) begin
            r_tag[i_way][i_idx] <= i_fill_tag;
        end
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            o_valid[w] = r_valid[w][i_idx];
            o_dirty[w] = r_dirty[w][i_idx];
            o_tags[w*TAG_BITS +: TAG_BITS] = r_tag[w][i_idx];
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Blocking write-back, write-allocate set-associative cache with 4x128b line transfers.
// Optional hit/miss counters when ASSOC_CACHE_PERF_EN is defined.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WAYS           = 2,
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_req_valid,
    output logic                        cpu_req_ready,
    input  logic [WORD_ADDR_BITS-1:0]   cpu_req_addr,
    input  logic [CPU_WIDTH-1:0]        cpu_req_data,
    input  logic [3:0]                  cpu_req_write,
    output logic                        cpu_resp_valid,
    output logic [CPU_WIDTH-1:0]        cpu_resp_data,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [WORD_ADDR_BITS-3:0]   mem_req_addr,
    output logic                        mem_req_rw,
    output logic                        mem_req_data_valid,
    input  logic                        mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]    mem_req_data_bits,
    output logic [15:0]                 mem_req_data_mask,
    input  logic                        mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]    mem_resp_data,
`ifdef ASSOC_CACHE_PERF_EN
    output logic [31:0]                 hit_count,
    output logic [31:0]                 miss_count,
`endif
    output logic [2:0]                  dbg_state
);

    localparam int IDX_BITS = index_bits(LINES);
    localparam int TAG_BITS = tag_bits(WORD_ADDR_BITS, LINES);
    localparam int WAY_BITS = way_bits(WAYS);
    localparam int DEPTH    = WAYS * LINES * BEATS_PER_LINE;

    state_t                    r_state, w_next;
    logic [WORD_ADDR_BITS-1:0] r_addr;
    logic [CPU_WIDTH-1:0]      r_wdata;
    logic [3:0]                r_wmask;
    logic [1:0]                r_beat;
    logic [WAY_BITS-1:0]       r_rr, r_victim;
    logic [TAG_BITS-1:0]       r_victim_tag;
    logic [MEM_DATA_BITS-1:0]  r_data [DEPTH];

    logic [TAG_BITS-1:0]       w_tag;
    logic [IDX_BITS-1:0]       w_idx;
    logic [1:0]                w_beat_sel, w_word_sel;
    logic [WAYS-1:0]           w_valid, w_dirty;
    logic [WAYS*TAG_BITS-1:0]  w_tags;
    logic                      w_hit, w_inv_found, w_access, w_store, w_fill_last;
    logic [WAY_BITS-1:0]       w_hit_way, w_inv_way, w_victim, w_meta_way;
    logic [MEM_DATA_BITS-1:0]  w_acc_beat, w_wb_beat, w_merged;

    assign w_tag      = r_addr[WORD_ADDR_BITS-1 -: TAG_BITS];
    assign w_idx      = r_addr[OFFSET_BITS +: IDX_BITS];
    assign w_beat_sel = r_addr[3:2];
    assign w_word_sel = r_addr[1:0];
    assign w_store    = (r_wmask != 4'd0);

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_valid[w] && (w_tags[w*TAG_BITS +: TAG_BITS] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_BITS'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_valid[w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_BITS'(w);
            end
        end
    end

    assign w_victim    = w_inv_found ? w_inv_way : r_rr;
    // REPLAY always hits: the fill just installed the requested tag.
    assign w_access    = ((r_state == ST_LOOKUP) && w_hit) || (r_state == ST_REPLAY);
    assign w_fill_last = (r_state == ST_FILL_DATA) && mem_resp_valid && (r_beat == 2'd3);
    assign w_meta_way  = (r_state == ST_FILL_DATA) ? r_victim : w_hit_way;
    assign w_acc_beat  = r_data[{w_hit_way, w_idx, w_beat_sel}];
    assign w_wb_beat   = r_data[{r_victim, w_idx, r_beat}];

    always_comb begin
        w_merged = w_acc_beat;
        for (int b = 0; b < 4; b++) begin
            if (r_wmask[b]) begin
                w_merged[int'(w_word_sel)*CPU_WIDTH + b*8 +: 8] = r_wdata[b*8 +: 8];
            end
        end
    end

    cache_meta_array #(
        .LINES    (LINES),
        .WAYS     (WAYS),
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS),
        .WAY_BITS (WAY_BITS)
    ) u_meta (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_idx       (w_idx),
        .i_way       (w_meta_way),
        .i_fill_we   (w_fill_last),
        .i_fill_tag  (w_tag),
        .i_set_dirty (w_access && w_store),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tags      (w_tags)
    );

    always_ff @(posedge clk) begin
        if ((r_state == ST_FILL_DATA) && mem_resp_valid) begin
            r_data[{r_victim, w_idx, r_beat}] <= mem_resp_data;
        end else if (w_access && w_store) begin
            r_data[{w_hit_way, w_idx, w_beat_sel}] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (cpu_req_valid) w_next = ST_LOOKUP;
            ST_LOOKUP:    if (w_hit) w_next = ST_IDLE;
                          else if (w_valid[w_victim] && w_dirty[w_victim]) w_next = ST_WB_REQ;
                          else w_next = ST_FILL_REQ;
            ST_WB_REQ:    if (mem_req_ready) w_next = ST_WB_DATA;
            ST_WB_DATA:   if (mem_req_data_ready && (r_beat == 2'd3)) w_next = ST_FILL_REQ;
            ST_FILL_REQ:  if (mem_req_ready) w_next = ST_FILL_DATA;
            ST_FILL_DATA: if (w_fill_last) w_next = ST_REPLAY;
            ST_REPLAY:    w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_req_ready      = (r_state == ST_IDLE) && reset;
        cpu_resp_valid     = w_access && !w_store;
        cpu_resp_data      = '0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        if (cpu_resp_valid) begin
            cpu_resp_data = w_acc_beat[int'(w_word_sel)*CPU_WIDTH +: CPU_WIDTH];
        end
        case (r_state)
            ST_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {r_victim_tag, w_idx, 2'b00};
            end
            ST_WB_DATA: begin
                mem_req_data_valid = 1'b1;
                mem_req_data_bits  = w_wb_beat;
                mem_req_data_mask  = 16'hFFFF;
            end
            ST_FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {w_tag, w_idx, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_beat       <= '0;
            r_rr         <= '0;
            r_victim     <= '0;
            r_victim_tag <= '0;
        end else begin
            if ((r_state == ST_IDLE) && cpu_req_valid) begin
                r_addr  <= cpu_req_addr;
                r_wdata <= cpu_req_data;
                r_wmask <= cpu_req_write;
            end
            if ((r_state == ST_LOOKUP) && !w_hit) begin
                r_victim     <= w_victim;
                r_victim_tag <= w_tags[int'(w_victim)*TAG_BITS +: TAG_BITS];
                r_rr         <= (r_rr == WAY_BITS'(WAYS - 1)) ? '0 : r_rr + WAY_BITS'(1);
            end
            if (((r_state == ST_WB_DATA) && mem_req_data_ready) ||
                ((r_state == ST_FILL_DATA) && mem_resp_valid)) begin
                r_beat <= r_beat + 2'd1;
            end
        end
    end

`ifdef ASSOC_CACHE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if (w_hit && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
            if (!w_hit && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
        end
    end
`endif

    assign dbg_state = r_state;

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (default geometry: 64 sets x 2 ways) with a behavioural memory.
module tb_assoc_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req_valid, cpu_req_ready;
    logic [29:0]  cpu_req_addr;
    logic [31:0]  cpu_req_data;
    logic [3:0]   cpu_req_write;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_data;
    logic         mem_req_valid, mem_req_ready, mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic         mem_req_data_valid, mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [2:0]   dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assoc_cache dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_req_valid      (cpu_req_valid),
        .cpu_req_ready      (cpu_req_ready),
        .cpu_req_addr       (cpu_req_addr),
        .cpu_req_data       (cpu_req_data),
        .cpu_req_write      (cpu_req_write),
        .cpu_resp_valid     (cpu_resp_valid),
        .cpu_resp_data      (cpu_resp_data),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_req_rw         (mem_req_rw),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data),
        .dbg_state          (dbg_state)
    );

    // Memory model: untouched beats hold word value 0x1000_0000 + word address.
    logic [127:0] mem_arr [logic [27:0]];
    logic [127:0] wb_q [$];
    logic [15:0]  wbm_q [$];
    int           n_rd = 0, n_wr = 0, beats_sent = 0, stab_err = 0;
    int           stall_req = 0, stall_dat = 0, fill_gap = 0;
    int           req_wait = 0, dat_wait = 0, fill_left = 0, fill_idx = 0, wb_idx = 0;
    bit           gap_phase = 0, off_rw = 0, prev_rv = 0, prev_rw = 0, prev_dv = 0;
    logic [27:0]  off_addr = '0, last_rd_addr = '0, last_wr_addr = '0, prev_ra = '0;
    logic [127:0] off_bits = '0, prev_db = '0;
    logic [15:0]  off_mask = '0, prev_dm = '0;

    function automatic logic [127:0] beat_val(input logic [27:0] a);
        logic [127:0] v;
        if (mem_arr.exists(a)) return mem_arr[a];
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = 32'h1000_0000 + 32'({a, 2'b00}) + 32'(i);
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
            mem_resp_valid = 1'b0; mem_resp_data = '0;
            fill_left = 0; req_wait = 0; dat_wait = 0; prev_rv = 0; prev_dv = 0;
        end else begin
            // A ready offered last negedge against a held valid completed at the posedge.
            if (mem_req_ready) begin
                if (off_rw) begin n_wr++; last_wr_addr = off_addr; wb_idx = 0; end
                else begin n_rd++; last_rd_addr = off_addr; fill_left = 4; fill_idx = 0; end
            end
            if (mem_req_data_ready) begin
                mem_arr[last_wr_addr + 28'(wb_idx)] = off_bits;
                wb_q.push_back(off_bits); wbm_q.push_back(off_mask); wb_idx++;
            end
            if (prev_rv && !mem_req_ready &&
                !(mem_req_valid && mem_req_addr == prev_ra && mem_req_rw == prev_rw)) stab_err++;
            if (prev_dv && !mem_req_data_ready &&
                !(mem_req_data_valid && mem_req_data_bits == prev_db && mem_req_data_mask == prev_dm)) stab_err++;
            prev_rv = mem_req_valid; prev_ra = mem_req_addr; prev_rw = mem_req_rw;
            prev_dv = mem_req_data_valid; prev_db = mem_req_data_bits; prev_dm = mem_req_data_mask;
            mem_resp_valid = 1'b0; mem_resp_data = '0;
            if (fill_left > 0) begin
                if (fill_gap != 0 && !gap_phase) gap_phase = 1'b1;
                else begin
                    gap_phase = 1'b0; mem_resp_valid = 1'b1;
                    mem_resp_data = beat_val(last_rd_addr + 28'(fill_idx));
                    fill_idx++; fill_left--; beats_sent++;
                end
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (req_wait < stall_req) req_wait++;
                else begin mem_req_ready = 1'b1; off_addr = mem_req_addr; off_rw = mem_req_rw; req_wait = 0; end
            end
            mem_req_data_ready = 1'b0;
            if (mem_req_data_valid) begin
                if (dat_wait < stall_dat) dat_wait++;
                else begin mem_req_data_ready = 1'b1; off_bits = mem_req_data_bits; off_mask = mem_req_data_mask; dat_wait = 0; end
            end
        end
    end

    // lat counts rising edges from the accept edge (edge 1) to the edge that captures the response.
    task automatic cpu_op(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                          output logic [31:0] rdata, output int lat, output int resp_cnt, output bit done);
        int n;
        rdata = '0; lat = 0; resp_cnt = 0; done = 0; n = 0;
        while (!cpu_req_ready && n < 1000) begin @(negedge clk); #1; n++; end
        cpu_req_valid = 1'b1; cpu_req_addr = a; cpu_req_data = d; cpu_req_write = m;
        @(negedge clk); #1;
        cpu_req_valid = 1'b0; cpu_req_write = 4'd0;
        for (n = 0; n < 1000; n++) begin
            if (cpu_resp_valid) begin rdata = cpu_resp_data; lat = n + 2; resp_cnt++; end
            if (cpu_req_ready) begin done = 1; break; end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_data = '0; cpu_req_write = '0;
        mem_req_ready = 1'b0; mem_req_data_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (cpu_req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", cpu_req_ready); end
        tests_run++; if (cpu_resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: got %b want 0", cpu_resp_valid); end
        tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid); end
        tests_run++; if (mem_req_data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_data_valid: got %b want 0", mem_req_data_valid); end
        tests_run++; if ({mem_req_addr, mem_req_data_mask, cpu_resp_data} !== '0) begin tests_failed++; $display("FAIL reset_outputs: got %h want 0", {mem_req_addr, mem_req_data_mask, cpu_resp_data}); end
        tests_run++; if (mem_req_data_bits !== '0) begin tests_failed++; $display("FAIL reset_data_bits: got %h want 0", mem_req_data_bits); end
        reset = 1'b1;
        @(negedge clk); #1;
        tests_run++; if (cpu_req_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_ready: got %b want 1", cpu_req_ready); end
        tests_run++; if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL idle_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_cold_load;
        logic [31:0] rd; int lat, rc, rd0, wr0, b0; bit done;
        rd0 = n_rd; wr0 = n_wr; b0 = beats_sent;
        cpu_op(30'h100, 32'h0, 4'h0, rd, lat, rc, done);
        tests_run++; if (!done || rc !== 1) begin tests_failed++; $display("FAIL cold_resp_count: got %0d (done %0b) want 1", rc, done); end
        tests_run++; if (rd !== 32'h1000_0100) begin tests_failed++; $display("FAIL cold_data: got %h want 10000100", rd); end
        tests_run++; if (n_rd - rd0 !== 1 || last_rd_addr !== 28'h40) begin tests_failed++; $display("FAIL cold_fill_req: got %0d reqs addr %h want 1 addr 40", n_rd - rd0, last_rd_addr); end
        tests_run++; if (beats_sent - b0 !== 4) begin tests_failed++; $display("FAIL cold_beats: got %0d want 4", beats_sent - b0); end
        tests_run++; if (n_wr !== wr0) begin tests_failed++; $display("FAIL cold_no_wb: got %0d writebacks want 0", n_wr - wr0); end
    endtask

    task automatic test_hit;
        logic [31:0] rd; int lat, rc, rd0, wr0; bit done;
        rd0 = n_rd; wr0 = n_wr;
        cpu_op(30'h105, 32'h0, 4'h0, rd, lat, rc, done);
        tests_run++; if (rd !== 32'h1000_0105) begin tests_failed++; $display("FAIL hit_data: got %h want 10000105", rd); end
        tests_run++; if (lat !== 2 || rc !== 1) begin tests_failed++; $display("FAIL hit_latency: got lat %0d resp %0d want lat 2 resp 1", lat, rc); end
        tests_run++; if (n_rd !== rd0 || n_wr !== wr0) begin tests_failed++; $display("FAIL hit_no_mem: got %0d rd %0d wr want 0 0", n_rd - rd0, n_wr - wr0); end
    endtask

    task automatic test_store_merge;
        logic [31:0] rd; int lat, rc, rd0; bit done;
        rd0 = n_rd;
        cpu_op(30'h102, 32'hDEAD_BEEF, 4'b0011, rd, lat, rc, done);
        tests_run++; if (!done || rc !== 0) begin tests_failed++; $display("FAIL store_no_resp: got %0d resp (done %0b) want 0", rc, done); end
        cpu_op(30'h102, 32'h0, 4'h0, rd, lat, rc, done);
        tests_run++; if (rd !== 32'h1000_BEEF) begin tests_failed++; $display("FAIL store_merge: got %h want 1000beef", rd); end
        tests_run++; if (n_rd !== rd0) begin tests_failed++; $display("FAIL store_hit: got %0d fills want 0", n_rd - rd0); end
    endtask

    task automatic test_conflict_writeback;
        logic [31:0] rd; logic [127:0] exp_beat; int lat, rc, rd0, wr0; bit done;
        stall_req = 5; stall_dat = 5; fill_gap = 1; stab_err = 0;
        wb_q.delete(); wbm_q.delete();
        wr0 = n_wr;
        cpu_op(30'h500, 32'h0, 4'h0, rd, lat, rc, done);
        tests_run++; if (rd !== 32'h1000_0500 || n_wr !== wr0) begin tests_failed++; $display("FAIL way1_fill: got %h wb %0d want 10000500 wb 0", rd, n_wr - wr0); end
        cpu_op(30'h900, 32'h0, 4'h0, rd, lat, rc, done);
        tests_run++; if (rd !== 32'h1000_0900) begin tests_failed++; $display("FAIL evict_data: got %h want 10000900", rd); end
        tests_run++; if (n_wr - wr0 !== 1 || last_wr_addr !== 28'h40) begin tests_failed++; $display("FAIL wb_req: got %0d addr %h want 1 addr 40", n_wr - wr0, last_wr_addr); end
        tests_run++; if (wb_q.size() !== 4) begin tests_failed++; $display("FAIL wb_beats: got %0d want 4", wb_q.size()); end
        for (int i = 0; i < 4 && i < wb_q.size(); i++) begin
            for (int j = 0; j < 4; j++) exp_beat[j*32 +: 32] = 32'h1000_0100 + 32'(4*i + j);
            if (i == 0) exp_beat[95:64] = 32'h1000_BEEF;
            tests_run++; if (wb_q[i] !== exp_beat || wbm_q[i] !== 16'hFFFF) begin tests_failed++; $display("FAIL wb_beat%0d: got %h/%h want %h/ffff", i, wb_q[i], wbm_q[i], exp_beat); end
        end
        tests_run++; if (stab_err !== 0) begin tests_failed++; $display("FAIL stall_stable: got %0d changes want 0", stab_err); end
        rd0 = n_rd; wr0 = n_wr;
        cpu_op(30'h102, 32'h0, 4'h0, rd, lat, rc, done);
        tests_run++; if (rd !== 32'h1000_BEEF || n_rd - rd0 !== 1 || n_wr !== wr0) begin tests_failed++; $display("FAIL refetch: got %h rd %0d wr %0d want 1000beef 1 0", rd, n_rd - rd0, n_wr - wr0); end
        stall_req = 0; stall_dat = 0; fill_gap = 0;
    endtask

    task automatic test_reset_mid_fill;
        logic [31:0] rd; int lat, rc, rd0, b0, n; bit done;
        b0 = beats_sent;
        cpu_req_valid = 1'b1; cpu_req_addr = 30'h3000; cpu_req_write = 4'h0;
        @(negedge clk); #1;
        cpu_req_valid = 1'b0;
        n = 0;
        while (beats_sent < b0 + 3 && n < 200) begin @(negedge clk); #1; n++; end
        tests_run++; if (beats_sent !== b0 + 3) begin tests_failed++; $display("FAIL midfill_reach_beat2: got %0d beats want 3", beats_sent - b0); end
        #1; reset = 1'b0; #1;
        tests_run++; if (dbg_state !== 3'd0 || cpu_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL midfill_abort: got state %0d ready %b mreq %b want 0 0 0", dbg_state, cpu_req_ready, mem_req_valid); end
        repeat (2) @(negedge clk);
        #1; reset = 1'b1;
        @(negedge clk); #1;
        rd0 = n_rd;
        cpu_op(30'h3000, 32'h0, 4'h0, rd, lat, rc, done);
        tests_run++; if (n_rd - rd0 !== 1) begin tests_failed++; $display("FAIL midfill_miss_again: got %0d fills want 1", n_rd - rd0); end
        tests_run++; if (rd !== 32'h1000_3000) begin tests_failed++; $display("FAIL midfill_data: got %h want 10003000", rd); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_load();
        test_hit();
        test_store_merge();
        test_conflict_writeback();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
